// File: rtl/gpio_port_pkg.sv
// gpio_port_pkg -- shared definitions for the GPIO port slice.
//
// Holds the register word map used by the bus decoder and the upper bound
// on the pin count. Imported by gpio_port.
package gpio_port_pkg;

    // Largest pin count a single port can expose (one full data word).
    localparam int unsigned N_PIN_MAX = 32;

    // Bus data width.
    localparam int unsigned DATA_W = 32;

    // Register word map (word index on i_mem_addr).
    typedef enum logic [2:0] {
        ADDR_ENO      = 3'd0,   // output enables, rw
        ADDR_IN       = 3'd1,   // synchronised pad inputs, ro
        ADDR_OUT      = 3'd2,   // output values, rw
        ADDR_OUT_SET  = 3'd3,   // set OUT bits, wo
        ADDR_OUT_CLR  = 3'd4,   // clear OUT bits, wo
        ADDR_OUT_TGL  = 3'd5,   // toggle OUT bits, wo
        ADDR_IRQ_EN   = 3'd6,   // interrupt enables, rw
        ADDR_IRQ_STAT = 3'd7    // interrupt status, write-1-to-clear
    } gpio_addr_e;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync -- multi-flop synchroniser for asynchronous pad inputs.
//
// Parameters:
//   WIDTH  number of independent bits
//   DEPTH  number of flops in the chain (2..3)
// Ports:
//   clk    sole clock
//   rst_n  synchronous active-low reset, clears every stage
//   d      asynchronous inputs
//   q      last stage of the chain
module gpio_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/gpio_port.sv
// gpio_port -- memory-mapped general purpose I/O port.
//
// Word-addressed register block driving N_PIN output pins with individual
// output enables, sampling N_PIN asynchronous pad inputs through a
// synchroniser, and (optionally) raising a level interrupt on pin edges.
//
// Build option:
//   GPIO_PORT_IRQ_EN  when defined, edge detection, IRQ_EN/IRQ_STAT registers
//                     and o_irq are implemented; otherwise addresses 6/7 read
//                     0, ignore writes, and o_irq is tied low.
//
// Parameters:
//   N_PIN   pin count (1..32)
//   N_SYNC  input synchroniser depth (2..3)
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_mem_valid     access request (accepted when no access is pending)
//   i_mem_addr      word index into the register map
//   i_mem_wen       write strobe
//   i_mem_wdata     write data (only low N_PIN bits used)
//   o_mem_ready     one-cycle pulse the cycle after acceptance
//   o_mem_rdata     read data, zero outside the ready cycle
//   o_gpio_eno      output enables
//   i_gpio_in       asynchronous pad inputs
//   o_gpio_out      output values
//   o_irq           registered level interrupt
module gpio_port
    import gpio_port_pkg::*;
#(
    parameter int unsigned N_PIN  = 8,
    parameter int unsigned N_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_valid,
    input  logic [2:0]        i_mem_addr,
    input  logic              i_mem_wen,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic              o_mem_ready,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic [N_PIN-1:0]  o_gpio_eno,
    input  logic [N_PIN-1:0]  i_gpio_in,
    output logic [N_PIN-1:0]  o_gpio_out,
    output logic              o_irq
);

    gpio_addr_e        addr;
    logic              accept;
    logic              wr;
    logic [N_PIN-1:0]  wdata;
    logic              unused_wdata;

    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [N_PIN-1:0]  eno_q;
    logic [N_PIN-1:0]  out_q;
    logic [N_PIN-1:0]  out_next;
    logic [N_PIN-1:0]  pin_sync;
    logic [N_PIN-1:0]  rd_val;
    logic [DATA_W-1:0] rd_ext;
    logic [N_PIN-1:0]  irq_en_rd;
    logic [N_PIN-1:0]  irq_stat_rd;

    assign addr   = gpio_addr_e'(i_mem_addr);
    // The ready cycle doubles as the pending flag, so requests held through
    // it are not accepted back-to-back.
    assign accept = i_mem_valid && !ready_q;
    assign wr     = accept && i_mem_wen;
    assign wdata  = i_mem_wdata[N_PIN-1:0];

    // Upper write-data bits are architecturally ignored.
    assign unused_wdata = ^i_mem_wdata;

    gpio_sync #(
        .WIDTH (N_PIN),
        .DEPTH (N_SYNC)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_gpio_in),
        .q     (pin_sync)
    );

`ifdef GPIO_PORT_IRQ_EN
    logic [N_PIN-1:0] prev_q;
    logic [N_PIN-1:0] irq_en_q;
    logic [N_PIN-1:0] irq_stat_q;
    logic [N_PIN-1:0] pin_edge;
    logic [N_PIN-1:0] stat_clr;
    logic             irq_q;

    assign pin_edge = prev_q ^ pin_sync;
    assign stat_clr = (wr && addr == ADDR_IRQ_STAT) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q     <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q <= pin_sync;
            if (wr && addr == ADDR_IRQ_EN) begin
                irq_en_q <= wdata;
            end
            // Set term is ORed after the clear so a coincident edge wins.
            irq_stat_q <= (irq_stat_q & ~stat_clr) | (pin_edge & irq_en_q);
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign irq_en_rd   = irq_en_q;
    assign irq_stat_rd = irq_stat_q;
    assign o_irq       = irq_q;
`else
    assign irq_en_rd   = '0;
    assign irq_stat_rd = '0;
    assign o_irq       = 1'b0;
`endif

    // Read mux; write-only and absent registers return zero.
    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_ENO:      rd_val = eno_q;
            ADDR_IN:       rd_val = pin_sync;
            ADDR_OUT:      rd_val = out_q;
            ADDR_IRQ_EN:   rd_val = irq_en_rd;
            ADDR_IRQ_STAT: rd_val = irq_stat_rd;
            default:       rd_val = '0;
        endcase
    end

    always_comb begin
        rd_ext              = '0;
        rd_ext[N_PIN-1:0]   = rd_val;
    end

    always_comb begin
        out_next = out_q;
        if (wr) begin
            case (addr)
                ADDR_OUT:     out_next = wdata;
                ADDR_OUT_SET: out_next = out_q | wdata;
                ADDR_OUT_CLR: out_next = out_q & ~wdata;
                ADDR_OUT_TGL: out_next = out_q ^ wdata;
                default:      out_next = out_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            eno_q   <= '0;
            out_q   <= '0;
        end else begin
            ready_q <= accept;
            rdata_q <= accept ? rd_ext : '0;
            out_q   <= out_next;
            if (wr && addr == ADDR_ENO) begin
                eno_q <= wdata;
            end
        end
    end

    assign o_mem_ready = ready_q;
    assign o_mem_rdata = rdata_q;
    assign o_gpio_eno  = eno_q;
    assign o_gpio_out  = out_q;

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port -- self-checking bench for gpio_port (N_PIN=8, N_SYNC=2).
// Register-map vectors from a table, directed sequences for the multi-cycle
// corner cases, then randomized traffic against a pad-history model.
module tb_gpio_port;

    localparam int unsigned NP = 8;
    localparam int unsigned NS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [2:0]    addr;
    logic          wen;
    logic [31:0]   wdata;
    logic          ready;
    logic [31:0]   rdata;
    logic [NP-1:0] eno;
    logic [NP-1:0] pad;
    logic [NP-1:0] gout;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    gpio_port #(.N_PIN(NP), .N_SYNC(NS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_valid (valid),
        .i_mem_addr  (addr),
        .i_mem_wen   (wen),
        .i_mem_wdata (wdata),
        .o_mem_ready (ready),
        .o_mem_rdata (rdata),
        .o_gpio_eno  (eno),
        .i_gpio_in   (pad),
        .o_gpio_out  (gout),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model. hist[k] is the pad value sampled k+1 edges ago, so the
    // synchronised input is hist[NS-1] and the previous sample is hist[NS].
    logic [NP-1:0] m_eno, m_out, m_en, m_stat;
    logic          m_irq, m_ready, m_rd_chk;
    logic [31:0]   m_rdata;
    logic [NP-1:0] hist [NS+1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_eno);
            3'd1:    return 32'(hist[NS-1]);
            3'd2:    return 32'(m_out);
            3'd6:    return 32'(m_en);
            3'd7:    return 32'(m_stat);
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock: update the model from the inputs present at the
    // edge, then compare all outputs shortly after it.
    task automatic tick();
        logic          acc;
        logic [NP-1:0] w, edg, stat_n;
        logic [31:0]   rdv;
        logic          irq_n;
        acc = valid && !m_ready;
        if (!rst_n) begin
            m_eno = '0; m_out = '0; m_en = '0; m_stat = '0;
            m_irq = 1'b0; m_ready = 1'b0; m_rdata = '0; m_rd_chk = 1'b0;
            for (int k = 0; k <= NS; k++) hist[k] = '0;
        end else begin
            w      = wdata[NP-1:0];
            rdv    = mread(addr);
            edg    = hist[NS-1] ^ hist[NS];
            stat_n = m_stat | (edg & m_en);
            irq_n  = |(m_stat & m_en);
            if (acc && wen) begin
                case (addr)
                    3'd0: m_eno = w;
                    3'd2: m_out = w;
                    3'd3: m_out = m_out | w;
                    3'd4: m_out = m_out & ~w;
                    3'd5: m_out = m_out ^ w;
`ifdef GPIO_PORT_IRQ_EN
                    3'd6: m_en = w;
                    3'd7: stat_n = (m_stat & ~w) | (edg & m_en);
`endif
                    default: ;
                endcase
            end
            m_stat   = stat_n;
            m_irq    = irq_n;
            m_ready  = acc;
            m_rdata  = acc ? rdv : 32'h0;
            m_rd_chk = acc && !wen;
            for (int k = NS; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pad;
        end
        @(posedge clk);
        #1;
        chk("ready", {31'b0, ready}, {31'b0, m_ready});
        chk("eno",   32'(eno),  32'(m_eno));
        chk("out",   32'(gout), 32'(m_out));
        chk("irq",   {31'b0, irq},  {31'b0, m_irq});
        if (m_rd_chk || !m_ready) chk("rdata", rdata, m_rdata);
    endtask

    // One bus access: accept edge, then the ready cycle.
    task automatic access(input logic [2:0] a, input logic we, input logic [31:0] d,
                          input logic chk_rd, input logic [31:0] exp);
        valid = 1'b1; addr = a; wen = we; wdata = d;
        tick();
        valid = 1'b0; wen = 1'b0;
        chk("acc_ready", {31'b0, ready}, 32'd1);
        if (chk_rd) chk($sformatf("rd_a%0d", a), rdata, exp);
        tick();
        chk("acc_ready_drop", {31'b0, ready}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  a;
        logic        we;
        logic [31:0] d;
        logic        chk_rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl = '{
            '{3'd0, 1'b1, 32'h0000_00FF, 1'b0, 32'h0},
            '{3'd2, 1'b1, 32'h0000_005A, 1'b0, 32'h0},
            '{3'd2, 1'b0, 32'h0,         1'b1, 32'h0000_005A},
            '{3'd0, 1'b0, 32'h0,         1'b1, 32'h0000_00FF},
            '{3'd2, 1'b1, 32'h0000_000F, 1'b0, 32'h0},
            '{3'd3, 1'b1, 32'h0000_00F0, 1'b0, 32'h0},
            '{3'd2, 1'b0, 32'h0,         1'b1, 32'h0000_00FF},
            '{3'd4, 1'b1, 32'h0000_0081, 1'b0, 32'h0},
            '{3'd2, 1'b0, 32'h0,         1'b1, 32'h0000_007E},
            '{3'd5, 1'b1, 32'h0000_00FF, 1'b0, 32'h0},
            '{3'd2, 1'b0, 32'h0,         1'b1, 32'h0000_0081},
            '{3'd3, 1'b0, 32'h0,         1'b1, 32'h0},
            '{3'd4, 1'b0, 32'h0,         1'b1, 32'h0},
            '{3'd5, 1'b0, 32'h0,         1'b1, 32'h0},
            '{3'd1, 1'b1, 32'h0000_0033, 1'b0, 32'h0},
            '{3'd1, 1'b0, 32'h0,         1'b1, 32'h0},
            '{3'd2, 1'b1, 32'hFFFF_FF3C, 1'b0, 32'h0},
            '{3'd2, 1'b0, 32'h0,         1'b1, 32'h0000_003C}
        };

        valid = 1'b0; addr = '0; wen = 1'b0; wdata = '0; pad = '0;
        do_reset();
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_eno",   32'(eno), 32'h0);
        chk("rst_out",   32'(gout), 32'h0);
        chk("rst_irq",   {31'b0, irq}, 32'd0);

        foreach (tbl[i]) access(tbl[i].a, tbl[i].we, tbl[i].d, tbl[i].chk_rd, tbl[i].exp);
        chk("eno_pins", 32'(eno), 32'h0000_00FF);

        // Input synchroniser latency: first read samples the old chain value.
        pad = 8'h04;
        access(3'd1, 1'b0, 32'h0, 1'b1, 32'h0);
        idle(NS);
        access(3'd1, 1'b0, 32'h0, 1'b1, 32'h0000_0004);

        // Request held through the ready cycle yields one pulse only.
        valid = 1'b1; addr = 3'd2; wen = 1'b0;
        tick();
        chk("hold_ready1", {31'b0, ready}, 32'd1);
        tick();
        chk("hold_ready2", {31'b0, ready}, 32'd0);
        valid = 1'b0;
        tick();
        chk("hold_ready3", {31'b0, ready}, 32'd0);

        // Reset in the ready cycle aborts the access and clears outputs.
        valid = 1'b1; addr = 3'd2; wen = 1'b0;
        tick();
        valid = 1'b0; rst_n = 1'b0;
        tick();
        chk("abort_ready", {31'b0, ready}, 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_out",   32'(gout), 32'h0);
        chk("abort_eno",   32'(eno), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("abort_noready", {31'b0, ready}, 32'd0);

`ifdef GPIO_PORT_IRQ_EN
        pad = 8'h00;
        do_reset();
        idle(NS + 1);
        access(3'd6, 1'b1, 32'h04, 1'b0, 32'h0);
        pad = 8'h04;
        idle(NS + 1);
        chk("irq_lat_lo", {31'b0, irq}, 32'd0);
        tick();
        chk("irq_lat_hi", {31'b0, irq}, 32'd1);
        access(3'd7, 1'b0, 32'h0, 1'b1, 32'h04);
        access(3'd7, 1'b1, 32'h04, 1'b0, 32'h0);
        access(3'd7, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        pad = 8'h00;
        idle(NS + 3);
        // Clearing the enable leaves status intact.
        access(3'd6, 1'b1, 32'h00, 1'b0, 32'h0);
        access(3'd7, 1'b0, 32'h0, 1'b1, 32'h04);
        access(3'd6, 1'b1, 32'h04, 1'b0, 32'h0);
        // W1C lands on the same edge as a new pin edge: set wins.
        pad = 8'h04;
        idle(NS);
        access(3'd7, 1'b1, 32'h04, 1'b0, 32'h0);
        access(3'd7, 1'b0, 32'h0, 1'b1, 32'h04);
`else
        pad = 8'h00;
        do_reset();
        access(3'd6, 1'b1, 32'hFF, 1'b0, 32'h0);
        access(3'd7, 1'b1, 32'hFF, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            pad = ~pad;
            idle(NS + 1);
        end
        access(3'd6, 1'b0, 32'h0, 1'b1, 32'h0);
        access(3'd7, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("irq_tied", {31'b0, irq}, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            valid = ($urandom_range(0, 2) != 0);
            addr  = 3'($urandom_range(0, 7));
            wen   = $urandom_range(0, 1) != 0;
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) pad = NP'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
